// File: rtl/bk_pkg.sv
// bk_pkg: shared Brent-Kung prefix types and helpers for the adder/subtractor datapath.
//   BK_WIDTH   default operand width
//   LOG2W      prefix tree depth for BK_WIDTH
//   gp_t       (generate, propagate) pair
//   gp_combine (G,P) prefix operator: hi covers the more significant span
package bk_pkg;

    localparam int unsigned BK_WIDTH = 16;
    localparam int unsigned LOG2W    = $clog2(BK_WIDTH);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_sub_pipe_if.sv
// bk_sub_pipe_if: streaming operand/result bundle for bk_sub_pipe.
//   in_valid/in_ready   operand beat handshake (X minuend, Y subtrahend, Bin borrow-in)
//   out_valid/out_ready result handshake (D = {borrow_out, difference})
//   zero/ovf            result flags, present only when BK_SUB_FLAGS_EN is defined
//   master: producer/consumer side; slave: the subtractor
interface bk_sub_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   D;
`ifdef BK_SUB_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, X, Y, Bin, out_ready,
        input  in_ready, out_valid, D, zero, ovf
    );

    modport slave (
        input  in_valid, X, Y, Bin, out_ready,
        output in_ready, out_valid, D, zero, ovf
    );
`else
    modport master (
        output in_valid, X, Y, Bin, out_ready,
        input  in_ready, out_valid, D
    );

    modport slave (
        input  in_valid, X, Y, Bin, out_ready,
        output in_ready, out_valid, D
    );
`endif
endinterface

// File: rtl/bk_prefix_cell.sv
// bk_prefix_cell: combinational (G,P) prefix node, one instance per tree node.
//   hi  (G,P) of the more significant span
//   lo  (G,P) of the adjacent less significant span
//   res (G,P) of the merged span
module bk_prefix_cell
    import bk_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t res
);

    assign res = gp_combine(hi, lo);

endmodule

// File: rtl/bk_sub_pipe.sv
// bk_sub_pipe: 3-stage pipelined Brent-Kung subtractor, D = {borrow_out, X - Y - Bin}.
//   clk, rst  clock and asynchronous active-high reset
//   bus       bk_sub_pipe_if slave: operand stream in, result stream out
// Optional zero/ovf result flags are built when BK_SUB_FLAGS_EN is defined.
// Stages: S1 registers X, ~Y, ~Bin; S2 registers the up-sweep; S3 down-sweep and D.
module bk_sub_pipe
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH = BK_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    bk_sub_pipe_if.slave bus
);

    localparam int unsigned LGW = (WIDTH == BK_WIDTH) ? LOG2W : $clog2(WIDTH);

    logic             advance;

    logic             v1;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] ny1;
    logic             cin1;

    logic             v2;
    gp_t              up2 [WIDTH];
    logic [WIDTH-1:0] p2;
    logic             cin2;

    logic             v3;
    logic [WIDTH:0]   d3;

    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] p1;
    gp_t              up [LGW+1][WIDTH];
    gp_t              dn [LGW][WIDTH];
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff;
    logic             borrow;

`ifdef BK_SUB_FLAGS_EN
    logic             xmsb2;
    logic             zero3;
    logic             ovf3;
    logic             zero_c;
    logic             ovf_c;
`endif

    // Whole pipe moves as one; bubbles travel with it.
    assign advance      = bus.out_ready | ~v3;
    assign bus.in_ready = advance;
    assign bus.out_valid = v3;
    assign bus.D        = d3;

    // S1: capture X, inverted Y and inverted borrow (carry-in of X + ~Y + ~Bin).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            x1   <= '0;
            ny1  <= '0;
            cin1 <= 1'b0;
        end else if (advance) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                x1   <= bus.X;
                ny1  <= ~bus.Y;
                cin1 <= ~bus.Bin;
            end
        end
    end

    assign g1 = x1 & ny1;
    assign p1 = x1 ^ ny1;

    // Leaf level; carry-in is folded into bit 0 so every prefix G is a carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        if (i == 0) begin : g_bit0
            assign up[0][i] = gp_t'{g: g1[i] | (p1[i] & cin1), p: p1[i]};
        end else begin : g_bitn
            assign up[0][i] = gp_t'{g: g1[i], p: p1[i]};
        end
    end

    // Up-sweep: level l merges pairs of 2^(l-1) spans ending at multiples of 2^l.
    for (genvar l = 1; l <= LGW; l++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (((i + 1) % (1 << l)) == 0) begin : g_cell
                bk_prefix_cell u_cell (
                    .hi  (up[l-1][i]),
                    .lo  (up[l-1][i - (1 << (l - 1))]),
                    .res (up[l][i])
                );
            end else begin : g_pass
                assign up[l][i] = up[l-1][i];
            end
        end
    end

    // S2: register the up-sweep result plus what the sum stage still needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            p2   <= '0;
            cin2 <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                up2[i] <= '0;
            end
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                p2   <= p1;
                cin2 <= cin1;
                for (int i = 0; i < WIDTH; i++) begin
                    up2[i] <= up[LGW][i];
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_dn0
        assign dn[0][i] = up2[i];
    end

    // Down-sweep: positions halfway between full prefixes pick up the prefix below them.
    for (genvar k = 1; k < LGW; k++) begin : g_dn
        localparam int H = 1 << (LGW - k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if ((((i + 1) % (2 * H)) == H) && ((i + 1) > 2 * H)) begin : g_cell
                bk_prefix_cell u_cell (
                    .hi  (dn[k-1][i]),
                    .lo  (dn[k-1][i - H]),
                    .res (dn[k][i])
                );
            end else begin : g_pass
                assign dn[k][i] = dn[k-1][i];
            end
        end
    end

    // Sum: carry into bit i is the prefix generate of bits i-1..0.
    always_comb begin
        carry    = '0;
        carry[0] = cin2;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = dn[LGW-1][i-1].g;
        end
        diff   = p2 ^ carry;
        borrow = ~dn[LGW-1][WIDTH-1].g;
    end

`ifdef BK_SUB_FLAGS_EN
    // Operand signs differ exactly when the MSB propagate of X ^ ~Y is 0.
    always_comb begin
        zero_c = (diff == '0);
        ovf_c  = ~p2[WIDTH-1] & (diff[WIDTH-1] ^ xmsb2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xmsb2 <= 1'b0;
        end else if (advance && v1) begin
            xmsb2 <= x1[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero3 <= 1'b0;
            ovf3  <= 1'b0;
        end else if (advance && v2) begin
            zero3 <= zero_c;
            ovf3  <= ovf_c;
        end
    end

    assign bus.zero = zero3;
    assign bus.ovf  = ovf3;
`endif

    // S3: result register and output valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3 <= 1'b0;
            d3 <= '0;
        end else if (advance) begin
            v3 <= v2;
            if (v2) begin
                d3 <= {borrow, diff};
            end
        end
    end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// tb_bk_sub_pipe: directed + scoreboard bench for bk_sub_pipe (WIDTH = 16).
// Flag checks are compiled in when BK_SUB_FLAGS_EN is defined.
module tb_bk_sub_pipe;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W:0] d;
        logic       zero;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_rx     = 0;
    exp_t exp_q [$];

    bk_sub_pipe_if #(.WIDTH(W)) bus ();

    bk_sub_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain 17-bit arithmetic; flags straight from their definitions.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
        exp_t       m;
        logic [W:0] full;
        full   = {1'b0, x} - {1'b0, y} - (W + 1)'(b);
        m.d    = full;
        m.zero = (full[W-1:0] == '0);
        m.ovf  = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid output is compared against the oldest outstanding beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(bus.D), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_D", 32'(bus.D), 32'(exp_q[0].d));
`ifdef BK_SUB_FLAGS_EN
                    chk("sb_zero", 32'(bus.zero), 32'(exp_q[0].zero));
                    chk("sb_ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
`endif
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_rx++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.X, bus.Y, bus.Bin));
            end
        end
    end

    // Present one beat and hold it until accepted; leaves junk on X/Y afterwards.
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
        bus.in_valid = 1'b1;
        bus.X        = x;
        bus.Y        = y;
        bus.Bin      = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                bus.in_valid = 1'b0;
                bus.X        = W'($urandom);
                bus.Y        = W'($urandom);
                bus.Bin      = 1'($urandom);
                return;
            end
            step();
        end
        n_checks++;
        n_err++;
        $display("FAIL drive_timeout: in_ready never seen at %0t", $time);
        bus.in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe: result exactly 3 edges after acceptance, one cycle wide.
    task automatic one_beat(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic b, input logic [W:0] exp_d, input logic ez, input logic eo);
        drive(x, y, b);
        @(negedge clk);
        chk({name, "_lat1"}, 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clk);
        chk({name, "_lat2"}, 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_D"}, 32'(bus.D), 32'(exp_d));
`ifdef BK_SUB_FLAGS_EN
        chk({name, "_zero"}, 32'(bus.zero), 32'(ez));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (ez === 1'bx || eo === 1'bx) $display("note: unknown flag expectation in %s", name);
`endif
        step();
        @(negedge clk);
        chk({name, "_pulse"}, 32'(bus.out_valid), 32'd0);
        step();
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    logic [W-1:0] bx [8];
    logic [W-1:0] by [8];
    logic         bb [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t m;
        int   rx0;

        bx = '{16'h0001, 16'h1000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h1234, 16'h4321};
        by = '{16'h0001, 16'h0FFF, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h4321, 16'h1234};
        bb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Pin the reference against hand-computed values.
        m = model(16'h0000, 16'hFFFF, 1'b1);
        chk("pin_model_wrap", 32'(m.d), 32'h0001_0000);
        m = model(16'h8000, 16'h0001, 1'b0);
        chk("pin_model_ovf", {15'd0, m.d}, 32'h0000_7FFF);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.X         = '0;
        bus.Y         = '0;
        bus.Bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_D", 32'(bus.D), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef BK_SUB_FLAGS_EN
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        step();

        one_beat("basic",   16'h000A, 16'h0005, 1'b0, 17'h00005, 1'b0, 1'b0);
        one_beat("borrow",  16'h0000, 16'h0001, 1'b0, 17'h1FFFF, 1'b0, 1'b0);
        one_beat("eq_bin",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0, 1'b0);
        one_beat("alt",     16'hAAAA, 16'h5555, 1'b1, 17'h05554, 1'b0, 1'b1);
        one_beat("ovf",     16'h8000, 16'h0001, 1'b0, 17'h07FFF, 1'b0, 1'b1);
        one_beat("zero",    16'h1234, 16'h1234, 1'b0, 17'h00000, 1'b1, 1'b0);

        // Eight back-to-back beats, then a 5-cycle stall while results are pending.
        rx0 = n_rx;
        fork
            begin
                for (int k = 0; k < 8; k++) drive(bx[k], by[k], bb[k]);
            end
            begin
                exp_t held;
                for (int c = 1; c <= 6; c++) begin
                    step();
                    @(negedge clk);
                    if (c >= 3) chk("burst_valid", 32'(bus.out_valid), 32'd1);
                end
                step();
                bus.out_ready = 1'b0;
                held = model(bx[4], by[4], bb[4]);
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_D", 32'(bus.D), 32'(held.d));
                    step();
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("burst_drain");
        chk("burst_count", 32'(n_rx - rx0), 32'd8);

        // Random operands with random backpressure.
        rx0 = n_rx;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    drive(W'($urandom), W'($urandom), 1'($urandom));
                end
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain("rand_drain");
        chk("rand_count", 32'(n_rx - rx0), 32'd40);

        // Reset with one result showing and two beats still in flight.
        drive(16'h0003, 16'h0001, 1'b0);
        drive(16'h0300, 16'h0001, 1'b0);
        drive(16'h3000, 16'h0001, 1'b0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_D", 32'(bus.D), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        one_beat("post_rst", 16'h0100, 16'h0001, 1'b0, 17'h000FF, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
